// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer with result capture and operand bypass
module reorder_buffer #(
    parameter int ROB_BIT = 3
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear,
    input  logic               issue_valid,
    input  logic               issue_has_rd,
    input  logic [4:0]         issue_rd,
    output logic [ROB_BIT-1:0] issue_rob_id,
    output logic               full,
    input  logic               rs_ready,
    input  logic [ROB_BIT-1:0] rs_rob_id,
    input  logic [31:0]        rs_value,
    input  logic               lsb_ready,
    input  logic [ROB_BIT-1:0] lsb_rob_id,
    input  logic [31:0]        lsb_value,
    input  logic [ROB_BIT-1:0] query_id1,
    input  logic [ROB_BIT-1:0] query_id2,
    output logic               query_ready1,
    output logic               query_ready2,
    output logic [31:0]        query_value1,
    output logic [31:0]        query_value2,
    output logic               commit_valid,
    output logic [ROB_BIT-1:0] commit_rob_id,
    output logic               commit_has_rd,
    output logic [4:0]         commit_rd,
    output logic [31:0]        commit_value
);
    localparam int SIZE = 1 << ROB_BIT;

    logic [SIZE-1:0]    busy_q, busy_d, ready_q, ready_d, has_rd_q, has_rd_d;
    logic [4:0]         rd_q [SIZE];
    logic [4:0]         rd_d [SIZE];
    logic [31:0]        value_q [SIZE];
    logic [31:0]        value_d [SIZE];
    logic [ROB_BIT-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_BIT:0]   count_q, count_d;
    logic               commit_valid_d, commit_has_rd_d;
    logic [ROB_BIT-1:0] commit_rob_id_d;
    logic [4:0]         commit_rd_d;
    logic [31:0]        commit_value_d;
    logic               do_issue, do_commit;
    logic               rs_hit1, rs_hit2, lsb_hit1, lsb_hit2;

    assign full         = count_q == (ROB_BIT+1)'(SIZE);
    assign issue_rob_id = tail_q;
    assign do_issue     = issue_valid && !full;
    assign do_commit    = busy_q[head_q] && ready_q[head_q];

    // Broadcast buses bypass into lookups so a consumer sees a result the cycle it appears.
    assign rs_hit1      = rs_ready && rs_rob_id == query_id1;
    assign rs_hit2      = rs_ready && rs_rob_id == query_id2;
    assign lsb_hit1     = lsb_ready && lsb_rob_id == query_id1;
    assign lsb_hit2     = lsb_ready && lsb_rob_id == query_id2;
    assign query_ready1 = ready_q[query_id1] || rs_hit1 || lsb_hit1;
    assign query_ready2 = ready_q[query_id2] || rs_hit2 || lsb_hit2;
    assign query_value1 = ready_q[query_id1] ? value_q[query_id1] : rs_hit1 ? rs_value : lsb_hit1 ? lsb_value : 32'd0;
    assign query_value2 = ready_q[query_id2] ? value_q[query_id2] : rs_hit2 ? rs_value : lsb_hit2 ? lsb_value : 32'd0;

    always_comb begin
        busy_d          = busy_q;
        ready_d         = ready_q;
        has_rd_d        = has_rd_q;
        rd_d            = rd_q;
        value_d         = value_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        commit_valid_d  = 1'b0;
        commit_rob_id_d = commit_rob_id;
        commit_has_rd_d = commit_has_rd;
        commit_rd_d     = commit_rd;
        commit_value_d  = commit_value;
        if (rdy_in && clear) begin
            busy_d  = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (rdy_in) begin
            // lsb is applied first so rs overwrites it when both target one entry
            if (lsb_ready && busy_q[lsb_rob_id]) begin
                value_d[lsb_rob_id] = lsb_value;
                ready_d[lsb_rob_id] = 1'b1;
            end
            if (rs_ready && busy_q[rs_rob_id]) begin
                value_d[rs_rob_id] = rs_value;
                ready_d[rs_rob_id] = 1'b1;
            end
            if (do_commit) begin
                commit_valid_d  = 1'b1;
                commit_rob_id_d = head_q;
                commit_has_rd_d = has_rd_q[head_q];
                commit_rd_d     = rd_q[head_q];
                commit_value_d  = value_q[head_q];
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = head_q + 1'b1;
            end
            if (do_issue) begin
                busy_d[tail_q]   = 1'b1;
                ready_d[tail_q]  = 1'b0;
                has_rd_d[tail_q] = issue_has_rd;
                rd_d[tail_q]     = issue_rd;
                tail_d           = tail_q + 1'b1;
            end
            count_d = count_q + (ROB_BIT+1)'(do_issue) - (ROB_BIT+1)'(do_commit);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q        <= '0;
            ready_q       <= '0;
            has_rd_q      <= '0;
            for (int i = 0; i < SIZE; i++) begin
                rd_q[i]    <= '0;
                value_q[i] <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            commit_valid  <= 1'b0;
            commit_rob_id <= '0;
            commit_has_rd <= 1'b0;
            commit_rd     <= '0;
            commit_value  <= '0;
        end else begin
            busy_q        <= busy_d;
            ready_q       <= ready_d;
            has_rd_q      <= has_rd_d;
            rd_q          <= rd_d;
            value_q       <= value_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            commit_valid  <= commit_valid_d;
            commit_rob_id <= commit_rob_id_d;
            commit_has_rd <= commit_has_rd_d;
            commit_rd     <= commit_rd_d;
            commit_value  <= commit_value_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed and random checks of reorder_buffer against a queue-based model
module tb_reorder_buffer;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, issue_valid, issue_has_rd;
    logic [4:0]  issue_rd;
    logic [2:0]  issue_rob_id;
    logic        full;
    logic        rs_ready, lsb_ready;
    logic [2:0]  rs_rob_id, lsb_rob_id, query_id1, query_id2;
    logic [31:0] rs_value, lsb_value;
    logic        query_ready1, query_ready2;
    logic [31:0] query_value1, query_value2;
    logic        commit_valid, commit_has_rd;
    logic [2:0]  commit_rob_id;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;

    int total = 0;
    int bad = 0;

    // model: ids in program order; the entry contents live in id-indexed arrays
    int          pend[$];
    int          m_tail;
    bit          m_rdy[8];
    bit          m_has[8];
    bit [4:0]    m_rd[8];
    bit [31:0]   m_val[8];
    bit          e_cv, e_chas;
    bit [2:0]    e_cid;
    bit [4:0]    e_crd;
    bit [31:0]   e_cval;

    reorder_buffer #(.ROB_BIT(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .issue_valid(issue_valid), .issue_has_rd(issue_has_rd), .issue_rd(issue_rd),
        .issue_rob_id(issue_rob_id), .full(full),
        .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .query_id1(query_id1), .query_id2(query_id2),
        .query_ready1(query_ready1), .query_ready2(query_ready2),
        .query_value1(query_value1), .query_value2(query_value2),
        .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
        .commit_has_rd(commit_has_rd), .commit_rd(commit_rd), .commit_value(commit_value)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit busy(input int id);
        foreach (pend[k]) if (pend[k] == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        pend.delete();
        m_tail = 0;
        e_cv = 0; e_chas = 0; e_cid = 0; e_crd = 0; e_cval = 0;
        for (int i = 0; i < 8; i++) m_rdy[i] = 0;
    endtask

    task automatic model_edge();
        bit cc, ci, lb, rb;
        int id;
        if (!rdy_in) begin
            e_cv = 0;
            return;
        end
        if (clear) begin
            pend.delete();
            m_tail = 0;
            e_cv = 0;
            return;
        end
        cc = pend.size() > 0 && m_rdy[pend[0]];
        ci = issue_valid && pend.size() < 8;
        lb = lsb_ready && busy(int'(lsb_rob_id));
        rb = rs_ready && busy(int'(rs_rob_id));
        e_cv = cc;
        if (cc) begin
            id = pend.pop_front();
            e_cid = 3'(id); e_chas = m_has[id]; e_crd = m_rd[id]; e_cval = m_val[id];
        end
        if (lb) begin m_val[lsb_rob_id] = lsb_value; m_rdy[lsb_rob_id] = 1; end
        if (rb) begin m_val[rs_rob_id] = rs_value; m_rdy[rs_rob_id] = 1; end
        if (ci) begin
            m_rdy[m_tail] = 0; m_has[m_tail] = issue_has_rd; m_rd[m_tail] = issue_rd;
            pend.push_back(m_tail);
            m_tail = (m_tail + 1) % 8;
        end
    endtask

    task automatic chk_query(input string tag, input logic [2:0] qid, input logic qr, input logic [31:0] qv);
        bit rh, lh, er;
        bit [31:0] ev;
        if (!busy(int'(qid))) return;
        rh = rs_ready && rs_rob_id == qid;
        lh = lsb_ready && lsb_rob_id == qid;
        er = m_rdy[qid] || rh || lh;
        ev = m_rdy[qid] ? m_val[qid] : rh ? rs_value : lh ? lsb_value : 32'd0;
        chk({tag, "_ready"}, 32'(qr), 32'(er));
        chk({tag, "_value"}, qv, ev);
    endtask

    task automatic check_model();
        chk("full", 32'(full), 32'(pend.size() == 8));
        chk("issue_rob_id", 32'(issue_rob_id), 32'(m_tail));
        chk_query("q1", query_id1, query_ready1, query_value1);
        chk_query("q2", query_id2, query_ready2, query_value2);
        chk("commit_valid", 32'(commit_valid), 32'(e_cv));
        if (e_cv) begin
            chk("commit_rob_id", 32'(commit_rob_id), 32'(e_cid));
            chk("commit_has_rd", 32'(commit_has_rd), 32'(e_chas));
            chk("commit_rd", 32'(commit_rd), 32'(e_crd));
            chk("commit_value", commit_value, e_cval);
        end
    endtask

    task automatic step();
        @(negedge clk_in);
        check_model();
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rdy_in = 1; clear = 0; issue_valid = 0; issue_has_rd = 0; issue_rd = 0;
        rs_ready = 0; rs_rob_id = 0; rs_value = 0;
        lsb_ready = 0; lsb_rob_id = 0; lsb_value = 0;
        query_id1 = 0; query_id2 = 0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_issue_id"}, 32'(issue_rob_id), 0);
        chk({tag, "_cvalid"}, 32'(commit_valid), 0);
        chk({tag, "_cid"}, 32'(commit_rob_id), 0);
        chk({tag, "_chas"}, 32'(commit_has_rd), 0);
        chk({tag, "_crd"}, 32'(commit_rd), 0);
        chk({tag, "_cval"}, commit_value, 0);
    endtask

    initial begin
        idle();
        rst_in = 0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        chk_reset_outs("reset");
        rst_in = 1;

        for (int i = 0; i < 8; i++) begin
            issue_valid = 1; issue_has_rd = 1; issue_rd = 5'(i + 1);
            chk("issue_seq", 32'(issue_rob_id), i);
            step();
        end
        chk("full_after_8", 32'(full), 1);
        issue_rd = 9;
        step();
        chk("ninth_ignored_tail", 32'(issue_rob_id), 0);
        chk("ninth_ignored_full", 32'(full), 1);
        issue_valid = 0;

        rs_ready = 1; rs_rob_id = 2; rs_value = 32'h22;
        step();
        chk("no_early_commit_a", 32'(commit_valid), 0);
        rs_rob_id = 1; rs_value = 32'h11;
        step();
        chk("no_early_commit_b", 32'(commit_valid), 0);
        rs_rob_id = 0; rs_value = 32'h00;
        step();
        chk("no_early_commit_c", 32'(commit_valid), 0);
        rs_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ooo_cvalid", 32'(commit_valid), 1);
            chk("ooo_cid", 32'(commit_rob_id), i);
            chk("ooo_cval", commit_value, 32'h11 * i);
            chk("ooo_crd", 32'(commit_rd), i + 1);
        end

        for (int i = 0; i < 3; i++) begin
            issue_valid = 1; issue_has_rd = 1; issue_rd = 5'(20 + i);
            step();
        end
        issue_valid = 0;
        chk("refill_full", 32'(full), 1);

        query_id1 = 3; lsb_ready = 1; lsb_rob_id = 3; lsb_value = 32'hDEAD;
        #1;
        chk("bypass_ready", 32'(query_ready1), 1);
        chk("bypass_value", query_value1, 32'hDEAD);
        step();
        lsb_ready = 0;

        issue_valid = 1; issue_rd = 30;
        chk("simul_full_before", 32'(full), 1);
        step();
        chk("simul_full_after", 32'(full), 0);
        chk("simul_rejected_tail", 32'(issue_rob_id), 3);
        chk("simul_commit_id", 32'(commit_rob_id), 3);
        chk("simul_commit_val", commit_value, 32'hDEAD);
        issue_valid = 0; rs_ready = 1; rs_rob_id = 4; rs_value = 32'h44;
        step();
        rs_ready = 0; issue_valid = 1; issue_rd = 31;
        step();
        chk("both_commit_id", 32'(commit_rob_id), 4);
        chk("both_tail", 32'(issue_rob_id), 4);
        chk("both_not_full", 32'(full), 0);
        issue_valid = 0;

        rs_ready = 1; rs_rob_id = 5; rs_value = 32'h55;
        step();
        rs_ready = 0; rdy_in = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pause_cvalid", 32'(commit_valid), 0);
            chk("pause_tail", 32'(issue_rob_id), 4);
        end
        rdy_in = 1;
        step();
        chk("resume_cvalid", 32'(commit_valid), 1);
        chk("resume_cid", 32'(commit_rob_id), 5);
        chk("resume_cval", commit_value, 32'h55);

        for (int n = 0; n < 400; n++) begin
            idle();
            rdy_in = ($urandom_range(7) != 0);
            clear = ($urandom_range(39) == 0);
            issue_valid = $urandom_range(1);
            issue_has_rd = $urandom_range(1);
            issue_rd = 5'($urandom);
            rs_ready = ($urandom_range(2) == 0);
            rs_rob_id = (pend.size() > 0 && $urandom_range(1)) ? 3'(pend[$urandom_range(pend.size() - 1)]) : 3'($urandom);
            rs_value = $urandom;
            lsb_ready = ($urandom_range(2) == 0);
            lsb_rob_id = (pend.size() > 0 && $urandom_range(1)) ? 3'(pend[$urandom_range(pend.size() - 1)]) : 3'($urandom);
            lsb_value = $urandom;
            query_id1 = (pend.size() > 0) ? 3'(pend[$urandom_range(pend.size() - 1)]) : 3'($urandom);
            query_id2 = 3'($urandom);
            step();
        end

        idle();
        clear = 1;
        step();
        clear = 0;
        for (int i = 0; i < 5; i++) begin
            issue_valid = 1; issue_has_rd = 1; issue_rd = 5'(i + 10);
            rs_ready = 1; rs_rob_id = 3'(i); rs_value = 32'(i + 100);
            step();
        end
        idle();
        #3;
        rst_in = 0;
        #1;
        chk_reset_outs("async_reset");
        model_reset();
        @(posedge clk_in);
        #1;
        rst_in = 1;
        chk("post_reset_issue_id", 32'(issue_rob_id), 0);
        repeat (4) begin
            step();
            chk("post_reset_no_commit", 32'(commit_valid), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
